// File: rtl/nes_pkg.sv
// Shared NES definitions: sprite DMA state encoding and the OAM DMA register address.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
    localparam int          XFER_LEN    = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: halts the CPU on a $4014 write and copies one 256-byte page into OAM,
// otherwise passing the CPU bus straight through to work RAM.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAMDMA_ADDR
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_w,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_w,
    input  logic [7:0]  mem_out,
    output logic        cpu_halt,
    output logic        oam_w,
    output logic [7:0]  oam_data,
    output logic [7:0]  oam_index,
    output dma_state_t  o_dbg_state
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t r_state;
    dma_state_t w_next_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_latch;
    logic [7:0] r_oam_index;
    logic       r_odd;
    logic       w_trigger;

    assign w_trigger = cpu_w && (cpu_address == DMA_REG_ADDR);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_trigger) w_next_state = HALT;
            HALT:    w_next_state = r_odd ? ALIGN : READ;
            ALIGN:   w_next_state = READ;
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = (r_idx == LAST_IDX) ? IDLE : READ;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath registers; r_oam_index remembers the last written slot once idx has moved on.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_odd       <= 1'b0;
            r_page      <= 8'h00;
            r_idx       <= 8'h00;
            r_latch     <= 8'h00;
            r_oam_index <= 8'h00;
        end else begin
            r_odd <= ~r_odd;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_page <= cpu_data;
                        r_idx  <= 8'h00;
                    end
                end
                READ: r_latch <= mem_out;
                WRITE: begin
                    r_oam_index <= r_idx;
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 8'h01;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_address = {r_page, r_idx};
        mem_data    = cpu_data;
        mem_w       = 1'b0;
        cpu_halt    = (r_state != IDLE);
        oam_w       = (r_state == WRITE);
        oam_data    = r_latch;
        oam_index   = r_oam_index;
        if (r_state == IDLE) begin
            mem_address = cpu_address;
            mem_w       = cpu_w;
        end
        if (r_state == WRITE) begin
            oam_index = r_idx;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: RAM model with low-page mirroring, scoreboard of expected OAM writes and halt lengths.
module tb_oam_dma;
    import nes_pkg::*;

    logic        CLK;
    logic        RESET_n;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_w;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_w;
    logic [7:0]  mem_out;
    logic        cpu_halt;
    logic        oam_w;
    logic [7:0]  oam_data;
    logic [7:0]  oam_index;
    dma_state_t  o_dbg_state;

    int tests_run = 0;
    int failures  = 0;
    int halt_cnt  = 0;
    int pulses_seen = 0;
    logic tb_odd;

    logic [15:0] exp_q[$];
    logic [15:0] exp_halt_q[$];
    logic [7:0]  ram [0:65535];

    oam_dma dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_w(cpu_w),
        .mem_address(mem_address), .mem_data(mem_data), .mem_w(mem_w),
        .mem_out(mem_out), .cpu_halt(cpu_halt),
        .oam_w(oam_w), .oam_data(oam_data), .oam_index(oam_index),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset-aware parity model
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) tb_odd <= 1'b0;
        else          tb_odd <= ~tb_odd;
    end

    // RAM model: 0000-1FFF mirrors the 2 KB work RAM
    function automatic logic [15:0] ram_map(input logic [15:0] a);
        return (a < 16'h2000) ? {5'b0, a[10:0]} : a;
    endfunction

    assign mem_out = ram[ram_map(mem_address)];

    always @(posedge CLK) begin
        if (RESET_n && mem_w) ram[ram_map(mem_address)] = mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (!RESET_n) begin
            exp_q.delete();
            exp_halt_q.delete();
            halt_cnt = 0;
        end else begin
            if (oam_w) begin
                pulses_seen++;
                if (exp_q.size() == 0) check("unexpected oam_w", 1, 0);
                else check("oam {index,data}", {16'h0, oam_index, oam_data}, {16'h0, exp_q.pop_front()});
            end
            if (cpu_halt) begin
                halt_cnt++;
            end else if (halt_cnt != 0) begin
                if (exp_halt_q.size() == 0) check("unexpected halt", 32'(halt_cnt), 0);
                else check("halt cycles", 32'(halt_cnt), {16'h0, exp_halt_q.pop_front()});
                halt_cnt = 0;
            end
        end
    end

    // driver tasks
    task automatic push_xfer(input logic [7:0] key, input logic [7:0] first);
        exp_q.push_back({8'h00, first});
        for (int k = 1; k < 256; k++) exp_q.push_back({8'(k), 8'(k) ^ key});
    endtask

    task automatic trigger(input logic [7:0] page, input logic align);
        @(negedge CLK);
        if (tb_odd == align) @(negedge CLK);
        pulses_seen = 0;
        cpu_address = OAMDMA_ADDR;
        cpu_data    = page;
        cpu_w       = 1'b1;
        #1;
        check("trigger passthrough mem_w", 32'(mem_w), 1);
        @(negedge CLK);
        cpu_w       = 1'b0;
        cpu_address = 16'h0000;
        check("state after trigger", 32'(o_dbg_state), 32'(HALT));
        check("cpu_halt after trigger", 32'(cpu_halt), 1);
        @(negedge CLK);
        check("state after halt", 32'(o_dbg_state), align ? 32'(ALIGN) : 32'(READ));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cpu_halt && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (cpu_halt) check("dma completion timeout", 1, 0);
        @(negedge CLK);
    endtask

    task automatic wait_pulses(input int target);
        int n;
        n = 0;
        while (pulses_seen < target && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (pulses_seen < target) check("oam pulse wait timeout", 32'(pulses_seen), 32'(target));
    endtask

    task automatic cpu_write_check(input logic [15:0] a, input logic [7:0] d, input logic exp_w);
        @(negedge CLK);
        cpu_address = a;
        cpu_data    = d;
        cpu_w       = 1'b1;
        #1;
        check("cpu write mem_w", 32'(mem_w), 32'(exp_w));
        if (exp_w) begin
            check("passthrough mem_address", 32'(mem_address), 32'(a));
            check("passthrough mem_data", 32'(mem_data), 32'(d));
        end
        @(negedge CLK);
        cpu_w       = 1'b0;
        cpu_address = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'h5A;
            ram[16'h0300 + 16'(i)] = 8'(i) ^ 8'hC3;
            ram[16'h0700 + 16'(i)] = 8'hFF;
        end
        ram[16'h0300] = 8'hA7;
        RESET_n = 1'b0;
        cpu_address = 16'h0000;
        cpu_data    = 8'h00;
        cpu_w       = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset cpu_halt", 32'(cpu_halt), 0);
        check("reset oam_w", 32'(oam_w), 0);
        check("reset oam_data", 32'(oam_data), 0);
        check("reset oam_index", 32'(oam_index), 0);
        check("reset state", 32'(o_dbg_state), 32'(IDLE));
        RESET_n = 1'b1;

        cpu_write_check(16'h0010, 8'h33, 1'b1);
        check("ram[0010] after write", 32'(ram[16'h0010]), 32'h33);

        // even parity: no ALIGN, 513 halt cycles; CPU write suppressed mid-transfer
        push_xfer(8'h5A, 8'h5A);
        exp_halt_q.push_back(16'd513);
        trigger(8'h02, 1'b0);
        repeat (20) @(negedge CLK);
        cpu_write_check(16'h0010, 8'h99, 1'b0);
        wait_idle();
        check("ram[0010] after suppressed write", 32'(ram[16'h0010]), 32'h33);
        check("state after dma", 32'(o_dbg_state), 32'(IDLE));
        cpu_write_check(16'h0011, 8'h5C, 1'b1);

        // odd parity: one ALIGN cycle, 514 halt cycles
        push_xfer(8'h5A, 8'h5A);
        exp_halt_q.push_back(16'd514);
        trigger(8'h02, 1'b1);
        wait_idle();

        // mirrored page 0B reads 0300..03FF
        push_xfer(8'hC3, 8'hA7);
        exp_halt_q.push_back(16'd513);
        trigger(8'h0B, 1'b0);
        wait_idle();

        // retrigger at byte 100 is ignored
        push_xfer(8'h5A, 8'h5A);
        exp_halt_q.push_back(16'd513);
        trigger(8'h02, 1'b0);
        wait_pulses(100);
        cpu_write_check(OAMDMA_ADDR, 8'h07, 1'b0);
        wait_idle();

        // reset mid-transfer
        push_xfer(8'h5A, 8'h5A);
        trigger(8'h02, 1'b1);
        wait_pulses(50);
        @(posedge CLK);
        #2;
        RESET_n = 1'b0;
        #1;
        check("async reset cpu_halt", 32'(cpu_halt), 0);
        check("async reset oam_w", 32'(oam_w), 0);
        check("async reset oam_data", 32'(oam_data), 0);
        check("async reset oam_index", 32'(oam_index), 0);
        check("async reset mem_w", 32'(mem_w), 0);
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        check("state after reset release", 32'(o_dbg_state), 32'(IDLE));
        check("cpu_halt after reset release", 32'(cpu_halt), 0);
        cpu_write_check(16'h0020, 8'h44, 1'b1);
        check("ram[0020] after write", 32'(ram[16'h0020]), 32'h44);
        repeat (3) @(negedge CLK);
        check("no stray halt", 32'(halt_cnt), 0);

        check("oam queue drained", 32'(exp_q.size()), 0);
        check("halt queue drained", 32'(exp_halt_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
